// File: rtl/serial_magnitude_compare_if.sv
// Operand/result bundle for the serial magnitude comparator.
// No latency of its own; pure wiring between requester and comparator.
// Requester drives start/operands; comparator returns busy, done pulse and flags.
interface serial_magnitude_compare_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    // Requester side: issues operations and watches the result.
    modport master (
        output start,
        output signed_mode,
        output a,
        output b,
        input  busy,
        input  done,
        input  gt,
        input  lt,
        input  eq
    );

    // Comparator side: accepts operations and reports the result.
    modport slave (
        input  start,
        input  signed_mode,
        input  a,
        input  b,
        output busy,
        output done,
        output gt,
        output lt,
        output eq
    );

endinterface

// File: rtl/serial_magnitude_compare.sv
// Multi-cycle MSB-digit-first magnitude comparator (signed/unsigned) with early exit.
// Latency: done in cycle after edge k+1 from start (k = first differing digit), NDIG for equal.
// Backpressure: start is only accepted while busy=0; start during a scan is ignored.
module serial_magnitude_compare #(
    parameter int WIDTH = 32,
    // Bits examined per cycle; WIDTH must be an integer multiple of DIGIT.
    parameter int DIGIT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    // Interface WIDTH must match this module's WIDTH.
    serial_magnitude_compare_if.slave     cmp
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [KW-1:0]    k_q, k_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    // Current digit under inspection and its relation between the two operands.
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_differ;
    logic             dig_a_gt;
    logic             last_dig;

    // Flipping the sign bit maps two's-complement onto offset binary, so the
    // same unsigned scan orders signed operands correctly.
    logic [WIDTH-1:0] sign_flip;

    assign sign_flip  = {cmp.signed_mode, {(WIDTH-1){1'b0}}};
    assign dig_a      = ra_q[WIDTH-1 -: DIGIT];
    assign dig_b      = rb_q[WIDTH-1 -: DIGIT];
    assign dig_differ = (dig_a != dig_b);
    assign dig_a_gt   = (dig_a > dig_b);
    assign last_dig   = (k_q == K_LAST);

    // State register; reset aborts any scan in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave SCAN on the first differing digit or after the last digit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmp.start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (dig_differ || last_dig) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, then shift until a result is known.
    always_comb begin
        ra_d   = ra_q;
        rb_d   = rb_q;
        k_d    = k_q;
        done_d = 1'b0;
        gt_d   = gt_q;
        lt_d   = lt_q;
        eq_d   = eq_q;
        case (state_q)
            IDLE: begin
                if (cmp.start) begin
                    ra_d = cmp.a ^ sign_flip;
                    rb_d = cmp.b ^ sign_flip;
                    k_d  = '0;
                    gt_d = 1'b0;
                    lt_d = 1'b0;
                    eq_d = 1'b0;
                end
            end
            SCAN: begin
                if (dig_differ) begin
                    gt_d   = dig_a_gt;
                    lt_d   = ~dig_a_gt;
                    eq_d   = 1'b0;
                    done_d = 1'b1;
                end else if (last_dig) begin
                    gt_d   = 1'b0;
                    lt_d   = 1'b0;
                    eq_d   = 1'b1;
                    done_d = 1'b1;
                end else begin
                    ra_d = ra_q << DIGIT;
                    rb_d = rb_q << DIGIT;
                    k_d  = k_q + KW'(1);
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; flags hold until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q   <= '0;
            rb_q   <= '0;
            k_q    <= '0;
            done_q <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            k_q    <= k_d;
            done_q <= done_d;
            gt_q   <= gt_d;
            lt_q   <= lt_d;
            eq_q   <= eq_d;
        end
    end

    // Outputs: busy follows the state directly so the done cycle is already idle.
    always_comb begin
        cmp.busy = (state_q == SCAN);
        cmp.done = done_q;
        cmp.gt   = gt_q;
        cmp.lt   = lt_q;
        cmp.eq   = eq_q;
    end

endmodule

// File: doc/serial_magnitude_compare.md
Name: serial_magnitude_compare

Overview:
Multi-cycle magnitude comparator for the ALU's compare and set-on-compare paths. It is the sequential counterpart to the single-cycle GT comparator. Operands are captured on a start handshake and scanned MSB-digit-first, with early termination on the first differing digit. The block reports greater-than, less-than and equal flags, with signed or unsigned interpretation selected per operation.

Parameters:
WIDTH, 32, operand width in bits
DIGIT, 1, bits examined per cycle; must divide WIDTH; NDIG = WIDTH/DIGIT

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result flags valid from this cycle
gt  output  1  A > B
lt  output  1  A < B
eq  output  1  A == B

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset: state=IDLE. busy, done, gt, lt and eq all 0. Digit index 0. Shift registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE and SCAN.
- IDLE:
  - If start=1 on a clock edge, load ra=a and rb=b.
  - If signed_mode=1, invert bit WIDTH-1 of both ra and rb at load. This offset-binary mapping makes the unsigned scan a correct signed compare.
  - On the same edge: clear gt, lt and eq; set digit index k=0; go to SCAN with busy=1.
- SCAN, on each edge:
  - Compare the top DIGIT bits of ra and rb as unsigned.
  - If they differ: gt = (ra digit > rb digit), lt = the inverse, eq=0, done=1, busy=0, state=IDLE.
  - Else if k = NDIG-1: eq=1, gt=0, lt=0, done=1, busy=0, state=IDLE.
  - Else: shift ra and rb left by DIGIT, k=k+1, stay in SCAN.
- Latency: the first differing digit index is k, with MSB digit k=0. done is high in the cycle after edge k+1 counted from the start edge. For equal operands, done follows edge NDIG. With DIGIT=1 that is 1 to 32 cycles.
- done is high for exactly one cycle.
- gt, lt and eq hold their values until the next start is accepted. Exactly one of them is 1 after done; all are 0 while busy.
- start while busy=1 is ignored. Operands and mode are not re-sampled and the operation in flight is unaffected.
- Back-to-back operation: in the done cycle, state is already IDLE and busy=0, so start is accepted on that edge. The next operation begins with no gap, and the flags clear on that edge.
- a, b and signed_mode may change freely while busy; only the values at the accepting edge matter.
- rst and start asserted on the same edge: reset wins.

Test Plan:
- Unsigned, DIGIT=1, a=0x00000001, b=0x00000000 -> done 32 cycles after start edge; gt=1, lt=0, eq=0; busy high for 32 cycles.
- Unsigned a=0x80000000, b=0x7FFFFFFF -> done 1 cycle after start; gt=1. Same operands with signed_mode=1 -> done 1 cycle after start; lt=1 (-2^31 < 2^31-1).
- a=b=0xDEADBEEF, both modes -> done after 32 cycles; eq=1, gt=0, lt=0. Repeat with DIGIT=4 -> done after 8 cycles.
- Signed a=0xFFFFFFFF (-1), b=0xFFFFFFFE (-2) -> gt=1 at cycle 32. Then raise start with a=5, b=9 (unsigned) in the done cycle -> flags clear on that edge; lt=1 with done 29 cycles later; no idle gap.
- start pulsed again at cycle 3 of an operation with different operands -> ignored; original result is reported at the original latency.
- rst asserted at cycle 10 of a 32-cycle compare -> next cycle busy=0, done=0, gt=lt=eq=0, and no done pulse follows. A fresh start afterwards completes normally.
